demux_8_to_8x4_stream: RTL and testbench

Routes a single 8-bit valid/ready byte stream to one of four 8-bit output channels. It performs the reverse of the design's 4:1 byte-bus selection. Each channel has a one-entry holding register with its own handshake, so one stalled consumer never corrupts another channel's data. The destination is either the `sel` input (directed mode) or an internal round-robin pointer (distribute mode).

---
 rtl/demux_8_to_8x4_stream.sv | 92 +++++++++
 tb/tb_demux_8_to_8x4_stream.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_8_to_8x4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux_8_to_8x4_stream
//  Purpose  : Routes one 8-bit valid/ready byte stream to one of four output
//             channels. Each channel owns a one-entry holding register with
//             its own handshake. The destination comes from sel (directed
//             mode) or from an internal round-robin pointer (distribute mode).
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             in_data/in_valid/in_ready - upstream byte stream
//             sel                       - destination in directed mode
//             rr_en                     - 1 = round-robin, 0 = directed
//             out0..out3                - channel holding registers
//             out_valid/out_ready       - per-channel downstream handshake
//             rr_ptr                    - next round-robin destination
//  Revision : 1.0  initial release
// ============================================================================
module demux_8_to_8x4_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] sel,
    input  logic       rr_en,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic [1:0] rr_ptr
);

    localparam int c_NCH = 4;

    logic [1:0] w_tgt;
    logic       w_accept;
    logic [1:0] r_ptr;
    logic [3:0] w_valid;
    logic [7:0] w_data [c_NCH];

    // Target is re-evaluated every cycle, so a mode switch takes effect at once.
    assign w_tgt    = rr_en ? r_ptr : sel;
    // A full target can still take a byte if it drains in the same cycle.
    assign in_ready = ~w_valid[w_tgt] | out_ready[w_tgt];
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar k = 0; k < c_NCH; k++) begin : g_chan
            localparam logic [1:0] c_IDX = 2'(k);

            logic [7:0] r_byte;
            logic       r_full;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_byte <= 8'h00;
                    r_full <= 1'b0;
                end else if (w_accept && (w_tgt == c_IDX)) begin
                    // Load wins over a simultaneous drain: no bubble.
                    r_byte <= in_data;
                    r_full <= 1'b1;
                end else if (out_ready[k]) begin
                    // Data is kept after a drain; only the valid flag clears.
                    r_full <= 1'b0;
                end
            end

            assign w_valid[k] = r_full;
            assign w_data[k]  = r_byte;
        end
    endgenerate

    // Pointer only moves on an accept in round-robin mode, so it never skips
    // past a full channel and per-channel order stays strictly cyclic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_accept && rr_en) begin
            r_ptr <= r_ptr + 2'd1;
        end
    end

    assign out0      = w_data[0];
    assign out1      = w_data[1];
    assign out2      = w_data[2];
    assign out3      = w_data[3];
    assign out_valid = w_valid;
    assign rr_ptr    = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_demux_8_to_8x4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_8_to_8x4_stream
//  Purpose  : Self-checking bench for demux_8_to_8x4_stream. The stimulus
//             side pushes each accepted byte into the queue of the channel
//             the bench model predicts; a monitor pops and compares whenever
//             a channel completes a downstream handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_8_to_8x4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic       rr_en;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] rr_ptr;

    demux_8_to_8x4_stream u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .rr_en     (rr_en),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    logic [1:0] m_ptr;

    logic [7:0] od [4];
    assign od[0] = out0;
    assign od[1] = out1;
    assign od[2] = out2;
    assign od[3] = out3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] d);
        case (ch)
            2'd0: q0.push_back(d);
            2'd1: q1.push_back(d);
            2'd2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic flush();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    // Monitor: a consumption happens at the next rising edge whenever the
    // channel is valid and its consumer is ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                for (int k = 0; k < 4; k++) begin
                    if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
                        logic [7:0] e;
                        int         sz;
                        case (k)
                            0: sz = q0.size();
                            1: sz = q1.size();
                            2: sz = q2.size();
                            default: sz = q3.size();
                        endcase
                        if (sz == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL mon_unexpected ch%0d: got %0h expected nothing", k, od[k]);
                        end else begin
                            case (k)
                                0: e = q0.pop_front();
                                1: e = q1.pop_front();
                                2: e = q2.pop_front();
                                default: e = q3.pop_front();
                            endcase
                            chk($sformatf("mon_ch%0d", k), 32'(od[k]), 32'(e));
                        end
                    end
                end
            end
        end
    end

    // Presents one byte and waits (bounded) for acceptance.
    task automatic send(input logic [7:0] d, input logic [1:0] s);
        int n;
        in_data  = d;
        sel      = s;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("accept_in_time", 32'(n < 20), 32'd1);
        if (n < 20) begin
            push(rr_en ? m_ptr : s, d);
            if (rr_en) m_ptr = m_ptr + 2'd1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        sel       = 2'd0;
        rr_en     = 1'b0;
        out_ready = 4'h0;
        m_ptr     = 2'd0;

        // 1. Reset with in_valid high: nothing captured.
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out0", 32'(out0), 32'h00);
        chk("rst_out1", 32'(out1), 32'h00);
        chk("rst_out2", 32'(out2), 32'h00);
        chk("rst_out3", 32'(out3), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // 2. Directed routing.
        out_ready = 4'hF;
        send(8'hA0, 2'd0);
        chk("dir_valid0", 32'(out_valid), 32'b0001);
        send(8'hA1, 2'd1);
        chk("dir_valid1", 32'(out_valid), 32'b0010);
        send(8'hA2, 2'd2);
        chk("dir_valid2", 32'(out_valid), 32'b0100);
        send(8'hA3, 2'd3);
        chk("dir_valid3", 32'(out_valid), 32'b1000);
        chk("dir_rr_ptr", 32'(rr_ptr), 32'd0);
        @(posedge clk); #1;

        // 3. Backpressure on channel 2.
        out_ready = 4'b1011;
        send(8'h55, 2'd2);
        in_data  = 8'h66;
        sel      = 2'd2;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out2_held", 32'(out2), 32'h55);
        @(posedge clk); #1;
        chk("bp_out2_stable", 32'(out2), 32'h55);
        out_ready = 4'hF;
        @(negedge clk);
        chk("bp_in_ready_release", 32'(in_ready), 32'd1);
        push(2'd2, 8'h66);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_valid2_kept", 32'(out_valid[2]), 32'd1);
        chk("bp_out2_new", 32'(out2), 32'h66);
        @(posedge clk); #1;

        // 4. Channel isolation.
        out_ready = 4'b1101;
        send(8'h11, 2'd1);
        send(8'h22, 2'd3);
        chk("iso_out1", 32'(out1), 32'h11);
        chk("iso_valid1", 32'(out_valid[1]), 32'd1);
        out_ready = 4'hF;
        @(posedge clk); #1;

        // 5. Round-robin.
        rr_en = 1'b1;
        chk("rr_ptr_start", 32'(rr_ptr), 32'd0);
        send(8'h10, 2'd3);
        chk("rr_ptr_1", 32'(rr_ptr), 32'd1);
        send(8'h20, 2'd3);
        chk("rr_ptr_2", 32'(rr_ptr), 32'd2);
        send(8'h30, 2'd3);
        chk("rr_ptr_3", 32'(rr_ptr), 32'd3);
        send(8'h40, 2'd3);
        chk("rr_ptr_0", 32'(rr_ptr), 32'd0);
        send(8'h50, 2'd3);
        chk("rr_ptr_1b", 32'(rr_ptr), 32'd1);
        @(posedge clk); #1;

        // 6. Fill channel 1 in directed mode, then stall round-robin on it.
        rr_en     = 1'b0;
        out_ready = 4'b1101;
        send(8'h77, 2'd1);
        chk("dir_keeps_ptr", 32'(rr_ptr), 32'd1);
        rr_en    = 1'b1;
        in_data  = 8'h88;
        sel      = 2'd0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("rr_stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rr_stall_ptr", 32'(rr_ptr), 32'd1);
        chk("rr_stall_out1", 32'(out1), 32'h77);
        rst = 1'b1;
        @(posedge clk); #1;
        flush();
        m_ptr    = 2'd0;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst2_out_valid", 32'(out_valid), 32'h0);
        chk("rst2_rr_ptr", 32'(rr_ptr), 32'd0);
        chk("rst2_out1", 32'(out1), 32'h00);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
